cnu_ctrl: RTL and testbench

CNU_CTRL -- requirements
Module: cnu_ctrl

---
 rtl/cnu_pkg.sv | 15 +
 rtl/cnu_ctrl_pipe.sv | 38 +++
 rtl/cnu_ctrl.sv | 127 ++++++++++++
 tb/tb_cnu_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnu_pkg.sv
// Shared definitions for the check-node-unit controller: FSM encoding and the
// cnu pipeline latency that the controller's delay line must track.
package cnu_pkg;

  localparam int LAT_DEFAULT = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_CHECK,
    S_DONE
  } state_t;

endpackage

// File: rtl/cnu_ctrl_pipe.sv
// Valid+address delay line mirroring the cnu datapath; shifts only when enabled
// so a stall freezes every in-flight row in place.
module cnu_ctrl_pipe #(
  parameter int depth = 3,
  parameter int ROW_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [ROW_W-1:0] in_addr,
  output logic             out_valid,
  output logic [ROW_W-1:0] out_addr
);

  logic [depth-1:0] r_valid;
  logic [ROW_W-1:0] r_addr [depth];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < depth; i++) begin
        r_addr[i] <= '0;
      end
    end else if (en) begin
      r_valid[0] <= in_valid;
      r_addr[0]  <= in_addr;
      for (int i = 1; i < depth; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_addr[i]  <= r_addr[i-1];
      end
    end
  end

  assign out_valid = r_valid[depth-1];
  assign out_addr  = r_addr[depth-1];

endmodule

// File: rtl/cnu_ctrl.sv
// Iteration controller for the check-node unit: sequences row reads, tracks the
// pipelined write-back, and decides convergence or iteration limit.
module cnu_ctrl
  import cnu_pkg::*;
#(
  parameter int ROWS     = 64,
  parameter int ROW_W    = 6,
  parameter int MAX_ITER = 10,
  parameter int ITER_W   = 4,
  parameter int LAT      = LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              syn_ok,
  output logic              rd_en,
  output logic [ROW_W-1:0]  rd_addr,
  output logic              cnu_en,
  output logic              wr_en,
  output logic [ROW_W-1:0]  wr_addr,
  output logic [ITER_W-1:0] iter,
  output logic              busy,
  output logic              done,
  output logic              converged
);

  localparam int DRAIN_W = $clog2(LAT + 1) + 1;

  state_t              r_state;
  logic [ROW_W-1:0]    r_rdPtr;
  logic [ITER_W-1:0]   r_iter;
  logic                r_converged;
  logic [DRAIN_W-1:0]  r_drainCnt;

  logic                w_rdEn;
  logic                w_cnuEn;
  logic                w_outValid;
  logic [ROW_W-1:0]    w_outAddr;

  assign w_rdEn  = (r_state == S_RUN) && !stall;
  assign w_cnuEn = ((r_state == S_RUN) || (r_state == S_DRAIN)) && !stall;

  cnu_ctrl_pipe #(
    .depth (LAT + 1),
    .ROW_W (ROW_W)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .en        (w_cnuEn),
    .in_valid  (w_rdEn),
    .in_addr   (r_rdPtr),
    .out_valid (w_outValid),
    .out_addr  (w_outAddr)
  );

  // The last row leaves the delay line LAT+1 enabled cycles after issue, so
  // counting enabled DRAIN cycles tells us when the line is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rdPtr     <= '0;
      r_iter      <= '0;
      r_converged <= 1'b0;
      r_drainCnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_rdPtr     <= '0;
            r_iter      <= '0;
            r_converged <= 1'b0;
            r_drainCnt  <= '0;
          end
        end
        S_RUN: begin
          if (!stall) begin
            r_rdPtr <= r_rdPtr + ROW_W'(1);
            if (r_rdPtr == ROW_W'(ROWS - 1)) begin
              r_state    <= S_DRAIN;
              r_drainCnt <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (!stall) begin
            if (r_drainCnt == DRAIN_W'(LAT)) begin
              r_state <= S_CHECK;
            end else begin
              r_drainCnt <= r_drainCnt + DRAIN_W'(1);
            end
          end
        end
        S_CHECK: begin
          if (syn_ok) begin
            r_converged <= 1'b1;
            r_state     <= S_DONE;
          end else if (r_iter == ITER_W'(MAX_ITER - 1)) begin
            r_state <= S_DONE;
          end else begin
            r_iter  <= r_iter + ITER_W'(1);
            r_rdPtr <= '0;
            r_state <= S_RUN;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_en     = w_rdEn;
  assign rd_addr   = r_rdPtr;
  assign cnu_en    = w_cnuEn;
  assign wr_en     = w_outValid && !stall;
  assign wr_addr   = w_outAddr;
  assign iter      = r_iter;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign converged = r_converged;

endmodule

// File: tb/tb_cnu_ctrl.sv
// Scoreboard bench for cnu_ctrl with ROWS=4, LAT=2, MAX_ITER=3: directed
// scenarios queue expected read/write/done events that a monitor consumes.
module tb_cnu_ctrl;

  localparam int ROWS     = 4;
  localparam int ROW_W    = 2;
  localparam int MAX_ITER = 3;
  localparam int ITER_W   = 2;
  localparam int LAT      = 2;

  typedef struct {
    int cyc;
    int addr;
    int iterVal;
  } ev_t;

  typedef struct {
    int cyc;
    int conv;
    int iterVal;
  } done_t;

  logic              clk;
  logic              rst;
  logic              start;
  logic              stall;
  logic              syn_ok;
  logic              rd_en;
  logic [ROW_W-1:0]  rd_addr;
  logic              cnu_en;
  logic              wr_en;
  logic [ROW_W-1:0]  wr_addr;
  logic [ITER_W-1:0] iter;
  logic              busy;
  logic              done;
  logic              converged;

  int    cyc;
  int    checkCount;
  int    passCount;
  int    busyCount;
  int    cnuCount;
  ev_t   rdQ[$];
  ev_t   wrQ[$];
  done_t doneQ[$];

  cnu_ctrl #(
    .ROWS     (ROWS),
    .ROW_W    (ROW_W),
    .MAX_ITER (MAX_ITER),
    .ITER_W   (ITER_W),
    .LAT      (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stall     (stall),
    .syn_ok    (syn_ok),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .cnu_en    (cnu_en),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .iter      (iter),
    .busy      (busy),
    .done      (done),
    .converged (converged)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running cycle index; scenario timings are offsets from it.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every DUT event must match the head of its queue, in cycle and content.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busyCount++;
      if (cnu_en) cnuCount++;
      if (stall) begin
        checkOutput("quiet under stall", {29'd0, rd_en, wr_en, cnu_en}, 0);
      end
      if (rd_en) begin
        if (rdQ.size() == 0) begin
          checkOutput("unexpected rd_en", 1, 0);
        end else begin
          ev_t e;
          e = rdQ.pop_front();
          checkOutput("rd cycle", cyc, e.cyc);
          checkOutput("rd addr", int'(rd_addr), e.addr);
        end
      end
      if (wr_en) begin
        if (wrQ.size() == 0) begin
          checkOutput("unexpected wr_en", 1, 0);
        end else begin
          ev_t e;
          e = wrQ.pop_front();
          checkOutput("wr cycle", cyc, e.cyc);
          checkOutput("wr addr", int'(wr_addr), e.addr);
          checkOutput("wr iter", int'(iter), e.iterVal);
        end
      end
      if (done) begin
        if (doneQ.size() == 0) begin
          checkOutput("unexpected done", 1, 0);
        end else begin
          done_t d;
          d = doneQ.pop_front();
          checkOutput("done cycle", cyc, d.cyc);
          checkOutput("done converged", int'(converged), d.conv);
          checkOutput("done iter", int'(iter), d.iterVal);
        end
      end
    end
  end

  task automatic waitUntil(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic s, input logic st, input logic syn);
    start  = s;
    stall  = st;
    syn_ok = syn;
  endtask

  // Unstalled iteration: reads at runStart..+3, writes LAT+1 cycles later.
  task automatic expectRun(input int runStart, input int iterVal);
    for (int r = 0; r < ROWS; r++) begin
      rdQ.push_back('{cyc: runStart + r, addr: r, iterVal: iterVal});
      wrQ.push_back('{cyc: runStart + r + LAT + 1, addr: r, iterVal: iterVal});
    end
  endtask

  task automatic expectDone(input int c, input int conv, input int iterVal);
    doneQ.push_back('{cyc: c, conv: conv, iterVal: iterVal});
  endtask

  task automatic beginScenario(output int t0);
    @(posedge clk);
    #1;
    t0        = cyc;
    busyCount = 0;
    cnuCount  = 0;
  endtask

  task automatic endScenario(input string name, input int expBusy, input int expCnu);
    checkOutput({name, " rd queue drained"}, rdQ.size(), 0);
    checkOutput({name, " wr queue drained"}, wrQ.size(), 0);
    checkOutput({name, " done queue drained"}, doneQ.size(), 0);
    checkOutput({name, " busy cycles"}, busyCount, expBusy);
    checkOutput({name, " cnu_en cycles"}, cnuCount, expCnu);
    rdQ.delete();
    wrQ.delete();
    doneQ.delete();
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, " outputs zero"},
                {16'd0, rd_en, rd_addr, cnu_en, wr_en, wr_addr, iter, busy, done, converged}, 0);
  endtask

  initial begin
    int t0;
    checkCount = 0;
    passCount  = 0;
    busyCount  = 0;
    cnuCount   = 0;
    rst        = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #2;
    checkAllZero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Converges on the first pass.
    beginScenario(t0);
    expectRun(t0 + 1, 0);
    expectDone(t0 + 9, 1, 0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitUntil(t0 + 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitUntil(t0 + 12);
    endScenario("single", 9, 7);

    // Never converges: runs to the iteration limit.
    beginScenario(t0);
    for (int k = 0; k < MAX_ITER; k++) expectRun(t0 + 1 + 8 * k, k);
    expectDone(t0 + 25, 0, 2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitUntil(t0 + 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitUntil(t0 + 28);
    checkOutput("limit iter held", int'(iter), 2);
    checkOutput("limit converged held", int'(converged), 0);
    endScenario("limit", 25, 21);

    // Two-cycle stall after the second read shifts everything downstream by two.
    beginScenario(t0);
    rdQ.push_back('{cyc: t0 + 1, addr: 0, iterVal: 0});
    rdQ.push_back('{cyc: t0 + 2, addr: 1, iterVal: 0});
    rdQ.push_back('{cyc: t0 + 5, addr: 2, iterVal: 0});
    rdQ.push_back('{cyc: t0 + 6, addr: 3, iterVal: 0});
    for (int r = 0; r < ROWS; r++) wrQ.push_back('{cyc: t0 + 6 + r, addr: r, iterVal: 0});
    expectDone(t0 + 11, 1, 0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitUntil(t0 + 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitUntil(t0 + 3);
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitUntil(t0 + 5);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitUntil(t0 + 14);
    endScenario("stall", 11, 7);

    // Reset during the second iteration's drain aborts without done.
    beginScenario(t0);
    expectRun(t0 + 1, 0);
    for (int r = 0; r < ROWS; r++) rdQ.push_back('{cyc: t0 + 9 + r, addr: r, iterVal: 1});
    wrQ.push_back('{cyc: t0 + 12, addr: 0, iterVal: 1});
    wrQ.push_back('{cyc: t0 + 13, addr: 1, iterVal: 1});
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitUntil(t0 + 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitUntil(t0 + 14);
    rst = 1'b1;
    #1;
    checkAllZero("abort");
    waitUntil(t0 + 15);
    rst = 1'b0;
    waitUntil(t0 + 30);
    endScenario("abort", 13, 12);

    beginScenario(t0);
    expectRun(t0 + 1, 0);
    expectDone(t0 + 9, 1, 0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitUntil(t0 + 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitUntil(t0 + 12);
    endScenario("restart", 9, 7);

    // start held through DONE: exactly one extra decode, launched from IDLE.
    beginScenario(t0);
    expectRun(t0 + 1, 0);
    expectDone(t0 + 9, 1, 0);
    expectRun(t0 + 11, 0);
    expectDone(t0 + 19, 1, 0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitUntil(t0 + 12);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitUntil(t0 + 26);
    endScenario("held start", 18, 14);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
